moxie_wb_ram: RTL and testbench

Wishbone classic-cycle responder (slave) for the core's instruction and data buses. It answers the fetch/write-stage initiators with a byte-addressable, big-endian on-chip RAM.
- Registered ACK with a configurable number of wait states.
- ERR response for addresses outside its window.
- Abort handling when the initiator withdraws STB.
One instance per bus port (I and D) in the SoC top.

---
 rtl/moxie_wb_pkg.sv | 33 +++
 rtl/moxie_wb_ram_if.sv | 41 ++++
 rtl/moxie_wb_ram_array.sv | 35 +++
 rtl/moxie_wb_ram.sv | 147 ++++++++++++++
 tb/tb_moxie_wb_ram.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/moxie_wb_pkg.sv
// moxie_wb_pkg: shared types and helpers for the Wishbone RAM responder.
// No ports. Imported by the bus interface, the RAM array and the top.
package moxie_wb_pkg;

    localparam int WB_DW   = 32;
    localparam int WB_SELW = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } wb_state_e;

    // Bit offset of the data lane owned by sel[i]. The bus is big-endian:
    // sel[3] owns dat[31:24], the lowest byte address of the word.
    function automatic int unsigned sel_lane_lsb(input int unsigned i);
        return 8 * i;
    endfunction

    // True when adr falls in the 4*2**aw byte window starting at base.
    // The base is window-aligned, so only the bits above the window
    // need to match.
    function automatic logic addr_hit(
        input logic [31:0] adr,
        input logic [31:0] base,
        input int unsigned aw
    );
        logic [31:0] mask;
        mask = ~((32'd4 << aw) - 32'd1);
        return ((adr ^ base) & mask) == 32'd0;
    endfunction

endpackage

// File: rtl/moxie_wb_ram_if.sv
// moxie_wb_ram_if: Wishbone classic-cycle bus between one initiator and
// the RAM responder. master drives adr/dat/sel/we/cyc/stb, slave drives
// dat_o/ack_o/err_o.
interface moxie_wb_ram_if;
    import moxie_wb_pkg::*;

    logic [31:0]        wb_adr_i;
    logic [WB_DW-1:0]   wb_dat_i;
    logic [WB_SELW-1:0] wb_sel_i;
    logic               wb_we_i;
    logic               wb_cyc_i;
    logic               wb_stb_i;
    logic [WB_DW-1:0]   wb_dat_o;
    logic               wb_ack_o;
    logic               wb_err_o;

    modport master (
        output wb_adr_i,
        output wb_dat_i,
        output wb_sel_i,
        output wb_we_i,
        output wb_cyc_i,
        output wb_stb_i,
        input  wb_dat_o,
        input  wb_ack_o,
        input  wb_err_o
    );

    modport slave (
        input  wb_adr_i,
        input  wb_dat_i,
        input  wb_sel_i,
        input  wb_we_i,
        input  wb_cyc_i,
        input  wb_stb_i,
        output wb_dat_o,
        output wb_ack_o,
        output wb_err_o
    );

endinterface

// File: rtl/moxie_wb_ram_array.sv
// moxie_wb_ram_array: single-port synchronous RAM, 2**ADDR_WIDTH x 32,
// per-byte write enables, registered read. Ports: clk_i, en_i, we_i[3:0],
// addr_i, wdata_i, rdata_o (updated on enabled edges only).
module moxie_wb_ram_array
    import moxie_wb_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk_i,
    input  logic                  en_i,
    input  logic [WB_SELW-1:0]    we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [WB_DW-1:0]      wdata_i,
    output logic [WB_DW-1:0]      rdata_o
);

    logic [WB_DW-1:0] mem_q [2**ADDR_WIDTH];
    logic [WB_DW-1:0] rdata_q;

    // Contents are deliberately not reset so this maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            for (int i = 0; i < WB_SELW; i++) begin
                if (we_i[i]) begin
                    mem_q[addr_i][sel_lane_lsb(i) +: 8] <=
                        wdata_i[sel_lane_lsb(i) +: 8];
                end
            end
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/moxie_wb_ram.sv
// moxie_wb_ram: Wishbone classic responder for a big-endian on-chip RAM.
// Ports: clk_i, rst_i (async, active-low), wb (slave modport of the bus).
module moxie_wb_ram
    import moxie_wb_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 12,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 1
) (
    input logic           clk_i,
    input logic           rst_i,
    moxie_wb_ram_if.slave wb
);

    localparam logic [3:0] WS = WAIT_STATES[3:0];

    wb_state_e              state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]  idx_q, idx_d;
    logic [WB_DW-1:0]       dat_q, dat_d;
    logic [WB_SELW-1:0]     sel_q, sel_d;
    logic                   we_q, we_d;
    logic                   hit_q, hit_d;
    logic                   ack_q, ack_d;
    logic                   err_q, err_d;

    logic                   req;
    logic                   go_resp;
    logic [ADDR_WIDTH-1:0]  cur_idx;
    logic [WB_DW-1:0]       cur_dat;
    logic [WB_SELW-1:0]     cur_sel;
    logic                   cur_we;
    logic                   cur_hit;
    logic                   ram_en;
    logic [WB_SELW-1:0]     ram_we;
    logic [WB_DW-1:0]       ram_rdata;

    always_comb begin
        req     = wb.wb_cyc_i & wb.wb_stb_i;
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        hit_d   = hit_q;
        go_resp = 1'b0;
        // The access that completes this edge: straight from the bus when
        // there are no wait states, otherwise the request latched in IDLE.
        cur_idx = idx_q;
        cur_dat = dat_q;
        cur_sel = sel_q;
        cur_we  = we_q;
        cur_hit = hit_q;

        unique case (state_q)
            ST_IDLE: begin
                cur_idx = wb.wb_adr_i[ADDR_WIDTH+1:2];
                cur_dat = wb.wb_dat_i;
                cur_sel = wb.wb_sel_i;
                cur_we  = wb.wb_we_i;
                cur_hit = addr_hit(wb.wb_adr_i, BASE_ADDR, ADDR_WIDTH);
                if (req) begin
                    idx_d = cur_idx;
                    dat_d = cur_dat;
                    sel_d = cur_sel;
                    we_d  = cur_we;
                    hit_d = cur_hit;
                    cnt_d = WS;
                    if (WS == 4'd0) begin
                        state_d = ST_RESP;
                        go_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!req) begin
                    // Initiator withdrew: drop the access silently.
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd1) begin
                    state_d = ST_RESP;
                    cnt_d   = 4'd0;
                    go_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ack_d  = go_resp & cur_hit;
        err_d  = go_resp & ~cur_hit;
        // A clock edge while reset is held must never touch the array.
        ram_en = go_resp & cur_hit & rst_i;
        ram_we = cur_we ? cur_sel : '0;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            hit_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            hit_q   <= hit_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    moxie_wb_ram_array #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_array (
        .clk_i  (clk_i),
        .en_i   (ram_en),
        .we_i   (ram_we),
        .addr_i (cur_idx),
        .wdata_i(cur_dat),
        .rdata_o(ram_rdata)
    );

    // Read data is only presented during a read ACK; the gate comes from
    // flops, so the output never follows bus inputs combinationally.
    assign wb.wb_ack_o = ack_q;
    assign wb.wb_err_o = err_q;
    assign wb.wb_dat_o = (ack_q & ~we_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_moxie_wb_ram.sv
// tb_moxie_wb_ram: bench for moxie_wb_ram. Instance A uses two wait
// states, instance B none; both share clock and reset.
module tb_moxie_wb_ram;

    localparam int WS_A  = 2;
    localparam int WS_B  = 0;
    localparam int LAT_A = WS_A + 1;
    localparam int LAT_B = WS_B + 1;

    logic clk;
    logic rst_i;
    int   checks;
    int   failures;
    int   cyc_n;
    int   ack_cnt_b;

    logic [31:0] model [int];

    moxie_wb_ram_if bus_a ();
    moxie_wb_ram_if bus_b ();

    moxie_wb_ram #(
        .ADDR_WIDTH (12),
        .BASE_ADDR  (32'h0000_0000),
        .WAIT_STATES(WS_A)
    ) dut_a (
        .clk_i(clk),
        .rst_i(rst_i),
        .wb   (bus_a)
    );

    moxie_wb_ram #(
        .ADDR_WIDTH (12),
        .BASE_ADDR  (32'h0000_0000),
        .WAIT_STATES(WS_B)
    ) dut_b (
        .clk_i(clk),
        .rst_i(rst_i),
        .wb   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_n++;

    always @(negedge clk) begin
        if (bus_b.wb_ack_o === 1'b1) ack_cnt_b++;
    end

    function automatic logic [31:0] merge(
        input logic [31:0] old,
        input logic [31:0] dat,
        input logic [3:0]  sel
    );
        logic [31:0] m;
        m = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
        return (old & ~m) | (dat & m);
    endfunction

    task automatic set_bus(
        input bit          use_b,
        input logic        req,
        input logic [31:0] adr,
        input logic [31:0] dat,
        input logic [3:0]  sel,
        input logic        we
    );
        if (use_b) begin
            bus_b.wb_cyc_i = req;
            bus_b.wb_stb_i = req;
            bus_b.wb_adr_i = adr;
            bus_b.wb_dat_i = dat;
            bus_b.wb_sel_i = sel;
            bus_b.wb_we_i  = we;
        end else begin
            bus_a.wb_cyc_i = req;
            bus_a.wb_stb_i = req;
            bus_a.wb_adr_i = adr;
            bus_a.wb_dat_i = dat;
            bus_a.wb_sel_i = sel;
            bus_a.wb_we_i  = we;
        end
    endtask

    task automatic sample(
        input bit           use_b,
        output logic        a,
        output logic        e,
        output logic [31:0] d
    );
        if (use_b) begin
            a = bus_b.wb_ack_o;
            e = bus_b.wb_err_o;
            d = bus_b.wb_dat_o;
        end else begin
            a = bus_a.wb_ack_o;
            e = bus_a.wb_err_o;
            d = bus_a.wb_dat_o;
        end
    endtask

    // Called at a falling edge. Holds the request until ACK/ERR (bounded),
    // drops it, then watches one more cycle. lat counts falling edges from
    // request to response; 0 means no response arrived.
    task automatic xfer(
        input bit           use_b,
        input logic [31:0]  adr,
        input logic [31:0]  dat,
        input logic [3:0]   sel,
        input logic         we,
        output int          lat,
        output logic        ack,
        output logic        err,
        output logic [31:0] rd,
        output logic        leak,
        output logic        linger,
        output int          ack_cyc
    );
        logic        a, e;
        logic [31:0] d;
        ack = 1'b0; err = 1'b0; rd = '0;
        leak = 1'b0; linger = 1'b0;
        lat = 0; ack_cyc = 0;
        set_bus(use_b, 1'b1, adr, dat, sel, we);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            sample(use_b, a, e, d);
            if (a === 1'b1 || e === 1'b1) begin
                ack = a; err = e; rd = d;
                lat = k; ack_cyc = cyc_n;
                break;
            end
            if (d !== 32'd0 || a !== 1'b0 || e !== 1'b0) leak = 1'b1;
        end
        set_bus(use_b, 1'b0, '0, '0, '0, 1'b0);
        @(negedge clk);
        sample(use_b, a, e, d);
        if (a !== 1'b0 || e !== 1'b0 || d !== 32'd0) linger = 1'b1;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        set_bus(1'b0, 1'b0, '0, '0, '0, 1'b0);
        set_bus(1'b1, 1'b0, '0, '0, '0, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if ({bus_a.wb_ack_o, bus_a.wb_err_o} !== 2'b00 || bus_a.wb_dat_o !== 32'd0) begin
            failures++;
            $display("FAIL reset_a ack=%b err=%b dat=%h want 0 0 0",
                     bus_a.wb_ack_o, bus_a.wb_err_o, bus_a.wb_dat_o);
        end
        checks++;
        if ({bus_b.wb_ack_o, bus_b.wb_err_o} !== 2'b00 || bus_b.wb_dat_o !== 32'd0) begin
            failures++;
            $display("FAIL reset_b ack=%b err=%b dat=%h want 0 0 0",
                     bus_b.wb_ack_o, bus_b.wb_err_o, bus_b.wb_dat_o);
        end
        rst_i = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat, c; logic a, e, lk, lg; logic [31:0] rd;
        xfer(1'b0, 32'h100, 32'hDEADBEEF, 4'hF, 1'b1, lat, a, e, rd, lk, lg, c);
        model[32'h100 >> 2] = 32'hDEADBEEF;
        checks++;
        if (a !== 1'b1 || e !== 1'b0 || lat != LAT_A || lg !== 1'b0) begin
            failures++;
            $display("FAIL basic_wr ack=%b err=%b lat=%0d linger=%b want 1 0 %0d 0",
                     a, e, lat, lg, LAT_A);
        end
        xfer(1'b0, 32'h100, 32'h0, 4'hF, 1'b0, lat, a, e, rd, lk, lg, c);
        checks++;
        if (rd !== 32'hDEADBEEF || a !== 1'b1 || lat != LAT_A) begin
            failures++;
            $display("FAIL basic_rd dat=%h ack=%b lat=%0d want deadbeef 1 %0d",
                     rd, a, lat, LAT_A);
        end
        checks++;
        if (lk !== 1'b0 || lg !== 1'b0) begin
            failures++;
            $display("FAIL basic_rd_idle leak=%b linger=%b want 0 0", lk, lg);
        end
    endtask

    task automatic test_byte_lanes();
        int lat, c; logic a, e, lk, lg; logic [31:0] rd;
        xfer(1'b0, 32'h100, 32'h11223344, 4'b1000, 1'b1, lat, a, e, rd, lk, lg, c);
        model[64] = merge(model[64], 32'h11223344, 4'b1000);
        xfer(1'b0, 32'h100, 32'h0, 4'hF, 1'b0, lat, a, e, rd, lk, lg, c);
        checks++;
        if (rd !== 32'h11ADBEEF) begin
            failures++;
            $display("FAIL lane_hi dat=%h want 11adbeef", rd);
        end
        xfer(1'b0, 32'h100, 32'h000000AA, 4'b0001, 1'b1, lat, a, e, rd, lk, lg, c);
        model[64] = merge(model[64], 32'h000000AA, 4'b0001);
        xfer(1'b0, 32'h102, 32'h0, 4'hF, 1'b0, lat, a, e, rd, lk, lg, c);
        checks++;
        if (rd !== 32'h11ADBEAA) begin
            failures++;
            $display("FAIL lane_lo dat=%h want 11adbeaa", rd);
        end
        xfer(1'b0, 32'h100, 32'hFFFFFFFF, 4'b0000, 1'b1, lat, a, e, rd, lk, lg, c);
        checks++;
        if (a !== 1'b1 || e !== 1'b0) begin
            failures++;
            $display("FAIL sel0_ack ack=%b err=%b want 1 0", a, e);
        end
        xfer(1'b0, 32'h100, 32'h0, 4'hF, 1'b0, lat, a, e, rd, lk, lg, c);
        checks++;
        if (rd !== model[64]) begin
            failures++;
            $display("FAIL sel0_nochange dat=%h want %h", rd, model[64]);
        end
    endtask

    task automatic test_miss();
        int lat, c; logic a, e, lk, lg; logic [31:0] rd;
        xfer(1'b0, 32'h4000, 32'h0, 4'hF, 1'b0, lat, a, e, rd, lk, lg, c);
        checks++;
        if (a !== 1'b0 || e !== 1'b1 || rd !== 32'd0 || lat != LAT_A) begin
            failures++;
            $display("FAIL miss_rd ack=%b err=%b dat=%h lat=%0d want 0 1 0 %0d",
                     a, e, rd, lat, LAT_A);
        end
        checks++;
        if (lg !== 1'b0) begin
            failures++;
            $display("FAIL miss_rd_pulse linger=%b want 0", lg);
        end
        // 0x4100 would land on word 0x40 (address 0x100) if it were not rejected.
        xfer(1'b0, 32'h4100, 32'h99999999, 4'hF, 1'b1, lat, a, e, rd, lk, lg, c);
        checks++;
        if (a !== 1'b0 || e !== 1'b1 || lat != LAT_A) begin
            failures++;
            $display("FAIL miss_wr ack=%b err=%b lat=%0d want 0 1 %0d",
                     a, e, lat, LAT_A);
        end
        xfer(1'b0, 32'h100, 32'h0, 4'hF, 1'b0, lat, a, e, rd, lk, lg, c);
        checks++;
        if (rd !== 32'h11ADBEAA) begin
            failures++;
            $display("FAIL miss_no_alias dat=%h want 11adbeaa", rd);
        end
    endtask

    task automatic test_abort();
        int lat, c, seen; logic a, e, lk, lg; logic [31:0] rd, d;
        xfer(1'b0, 32'h200, 32'h55AA55AA, 4'hF, 1'b1, lat, a, e, rd, lk, lg, c);
        model[128] = 32'h55AA55AA;
        set_bus(1'b0, 1'b1, 32'h200, 32'hFFFFFFFF, 4'hF, 1'b1);
        @(negedge clk);
        set_bus(1'b0, 1'b0, '0, '0, '0, 1'b0);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            sample(1'b0, a, e, d);
            if (a !== 1'b0 || e !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL abort_resp responses=%0d want 0", seen);
        end
        xfer(1'b0, 32'h200, 32'h0, 4'hF, 1'b0, lat, a, e, rd, lk, lg, c);
        checks++;
        if (rd !== 32'h55AA55AA || lat != LAT_A) begin
            failures++;
            $display("FAIL abort_nowrite dat=%h lat=%0d want 55aa55aa %0d",
                     rd, lat, LAT_A);
        end
    endtask

    task automatic test_reset_mid();
        int lat, c; logic a, e, lk, lg; logic [31:0] rd, d;
        xfer(1'b0, 32'h300, 32'hCAFEF00D, 4'hF, 1'b1, lat, a, e, rd, lk, lg, c);
        model[192] = 32'hCAFEF00D;
        set_bus(1'b0, 1'b1, 32'h300, 32'h12345678, 4'hF, 1'b1);
        @(negedge clk);
        #2 rst_i = 1'b0;
        #1;
        checks++;
        if ({bus_a.wb_ack_o, bus_a.wb_err_o} !== 2'b00 || bus_a.wb_dat_o !== 32'd0) begin
            failures++;
            $display("FAIL rst_wait ack=%b err=%b dat=%h want 0 0 0",
                     bus_a.wb_ack_o, bus_a.wb_err_o, bus_a.wb_dat_o);
        end
        @(negedge clk);
        set_bus(1'b0, 1'b0, '0, '0, '0, 1'b0);
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus_a.wb_ack_o, bus_a.wb_err_o} !== 2'b00) begin
            failures++;
            $display("FAIL rst_release ack=%b err=%b want 0 0",
                     bus_a.wb_ack_o, bus_a.wb_err_o);
        end
        xfer(1'b0, 32'h300, 32'h0, 4'hF, 1'b0, lat, a, e, rd, lk, lg, c);
        checks++;
        if (rd !== 32'hCAFEF00D || lat != LAT_A) begin
            failures++;
            $display("FAIL rst_nowrite dat=%h lat=%0d want cafef00d %0d",
                     rd, lat, LAT_A);
        end
        // Reset while ACK and read data are on the bus.
        set_bus(1'b0, 1'b1, 32'h300, 32'h0, 4'hF, 1'b0);
        a = 1'b0;
        for (int k = 0; k < 10 && a !== 1'b1; k++) begin
            @(negedge clk);
            sample(1'b0, a, e, d);
        end
        checks++;
        if (a !== 1'b1 || d !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL rst_resp_pre ack=%b dat=%h want 1 cafef00d", a, d);
        end
        #2 rst_i = 1'b0;
        #1;
        checks++;
        if (bus_a.wb_ack_o !== 1'b0 || bus_a.wb_dat_o !== 32'd0) begin
            failures++;
            $display("FAIL rst_resp_async ack=%b dat=%h want 0 0",
                     bus_a.wb_ack_o, bus_a.wb_dat_o);
        end
        set_bus(1'b0, 1'b0, '0, '0, '0, 1'b0);
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat, c, prev; logic a, e, lk, lg; logic [31:0] rd;
        prev = 0;
        for (int i = 0; i < 3; i++) begin
            xfer(1'b0, 32'h100, 32'h0, 4'hF, 1'b0, lat, a, e, rd, lk, lg, c);
            if (i > 0) begin
                checks++;
                if (c - prev != WS_A + 2 || rd !== model[64]) begin
                    failures++;
                    $display("FAIL b2b_a gap=%0d dat=%h want %0d %h",
                             c - prev, rd, WS_A + 2, model[64]);
                end
            end
            prev = c;
        end
    endtask

    task automatic test_random();
        int lat, c, w;
        logic a, e, lk, lg, we, hit;
        logic [31:0] rd, adr, dat, exp_rd;
        logic [3:0] sel;
        int unsigned pool [8];
        for (int i = 0; i < 8; i++) begin
            pool[i] = $urandom_range(256, 4095);
            dat = $urandom;
            xfer(1'b0, pool[i] * 4, dat, 4'hF, 1'b1, lat, a, e, rd, lk, lg, c);
            model[int'(pool[i])] = dat;
        end
        for (int n = 0; n < 40; n++) begin
            sel = 4'($urandom_range(0, 15));
            we  = 1'($urandom_range(0, 1));
            dat = $urandom;
            if ($urandom_range(0, 4) == 0) begin
                adr = $urandom;
                if (adr < 32'h4000) adr = adr + 32'h4000;
            end else begin
                adr = pool[$urandom_range(0, 7)] * 4 + $urandom_range(0, 3);
            end
            hit = adr < 32'h4000;
            w = int'(adr >> 2);
            exp_rd = 32'd0;
            if (hit && we) model[w] = merge(model[w], dat, sel);
            if (hit && !we) exp_rd = model[w];
            xfer(1'b0, adr, dat, sel, we, lat, a, e, rd, lk, lg, c);
            checks++;
            if (a !== hit || e !== !hit || lat != LAT_A) begin
                failures++;
                $display("FAIL rnd_resp adr=%h ack=%b err=%b lat=%0d want %b %b %0d",
                         adr, a, e, lat, hit, !hit, LAT_A);
            end
            if (!we || !hit) begin
                checks++;
                if (rd !== exp_rd) begin
                    failures++;
                    $display("FAIL rnd_data adr=%h dat=%h want %h", adr, rd, exp_rd);
                end
            end
            checks++;
            if (lk !== 1'b0 || lg !== 1'b0) begin
                failures++;
                $display("FAIL rnd_idle adr=%h leak=%b linger=%b want 0 0",
                         adr, lk, lg);
            end
        end
    endtask

    task automatic test_fetch();
        int lat, c, prev, base_cnt; logic a, e, lk, lg; logic [31:0] rd;
        for (int i = 0; i < 4; i++) begin
            xfer(1'b1, 32'(i * 4), 32'(i + 1), 4'hF, 1'b1, lat, a, e, rd, lk, lg, c);
        end
        base_cnt = ack_cnt_b;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            xfer(1'b1, 32'(i * 4), 32'h0, 4'hF, 1'b0, lat, a, e, rd, lk, lg, c);
            checks++;
            if (rd !== 32'(i + 1) || lat != LAT_B || lg !== 1'b0) begin
                failures++;
                $display("FAIL fetch_rd%0d dat=%h lat=%0d linger=%b want %h %0d 0",
                         i, rd, lat, lg, 32'(i + 1), LAT_B);
            end
            if (i > 0) begin
                checks++;
                if (c - prev != WS_B + 2) begin
                    failures++;
                    $display("FAIL fetch_gap%0d gap=%0d want %0d",
                             i, c - prev, WS_B + 2);
                end
            end
            prev = c;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (ack_cnt_b - base_cnt != 4) begin
            failures++;
            $display("FAIL fetch_acks count=%0d want 4", ack_cnt_b - base_cnt);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        cyc_n = 0;
        ack_cnt_b = 0;
        test_reset();
        test_basic();
        test_byte_lanes();
        test_miss();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_fetch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
